// File: rtl/shift_in_deser_reg_pkg.sv
// Shared definitions for the serial shift-in/shift-out register family:
// assembler FSM encoding and shift-direction constants.
package shift_in_deser_reg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic SHIFT_LEFT  = 1'b0;  // MSB first
  localparam logic SHIFT_RIGHT = 1'b1;  // LSB first

endpackage

// File: rtl/shift_in_deser_reg_out_buf.sv
// One-entry valid/ready holding register for assembled words, with a sticky
// overrun flag for words that arrive while the entry is full and not draining.
module deser_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             dout_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic free;
  assign free = !dout_valid || dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load && free) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      // a new drop outranks a clear on the same edge
      if (load && !free)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_in_deser_reg.sv
// Serial-in/parallel-out receiver: assembles WIDTH bits MSB- or LSB-first and
// hands each word to a one-entry valid/ready buffer.
module shift_in_deser_reg
  import shift_in_deser_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_sync,
  input  logic             shift_left_right,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic             mode;
  logic             done;

  logic             restart;
  logic             bit_mode;
  logic             last_bit;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] sr_next;

  // bit 0 of a word: either the first bit out of IDLE or a resync mid-word
  assign restart  = sin_valid && ((state == ST_IDLE) || frame_sync);
  assign bit_mode = restart ? shift_left_right : mode;
  assign base     = restart ? '0 : sr;
  assign sr_next  = (bit_mode == SHIFT_RIGHT) ? {sin, base[WIDTH-1:1]}
                                              : {base[WIDTH-2:0], sin};
  assign last_bit = sin_valid && !restart && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      sr    <= '0;
      mode  <= SHIFT_LEFT;
      done  <= 1'b0;
    end else begin
      done <= last_bit;
      if (sin_valid) begin
        sr <= sr_next;
        if (restart) begin
          mode  <= shift_left_right;
          cnt   <= CNT_W'(1);
          state <= ST_SHIFT;
          busy  <= 1'b1;
        end else if (last_bit) begin
          cnt   <= '0;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          cnt   <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // sr holds the finished word for exactly the cycle done is high
  deser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk         (clk),
    .reset       (reset),
    .load        (done),
    .word        (sr),
    .dout_ready  (dout_ready),
    .clr_overrun (clr_overrun),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .overrun     (overrun)
  );

endmodule
